// File: rtl/eth_pkg.sv
// Shared Ethernet MAC-control constants and the PAUSE receive FSM state type.
package eth_pkg;

  localparam logic [47:0] PAUSE_DA      = 48'h0180_C200_0001;
  localparam logic [15:0] MAC_CTRL_TYPE = 16'h8808;
  localparam logic [15:0] PAUSE_OPCODE  = 16'h0001;

  // Byte 17 is the last header byte (quanta LSB); the index parks at 18.
  localparam logic [4:0] HDR_LAST_IDX = 5'd17;
  localparam logic [4:0] IDX_SAT      = 5'd18;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    MATCHED,
    DISCARD
  } rx_state_e;

  // Byte idx (0 = first on the wire) of a 48-bit MAC address.
  function automatic logic [7:0] addr_byte(input logic [47:0] addr, input logic [2:0] idx);
    logic [47:0] sh;
    sh = addr << (8 * idx);
    return sh[47:40];
  endfunction

endpackage

// File: rtl/pause_rx_if.sv
// Byte-wide MAC receive stream: DA first, preamble/SFD already stripped.
interface pause_rx_if;
  logic [7:0] rx_mac_data;
  logic       rx_mac_valid;
  logic       rx_mac_last;
  logic       rx_mac_err;

  modport master (output rx_mac_data, rx_mac_valid, rx_mac_last, rx_mac_err);
  modport slave  (input  rx_mac_data, rx_mac_valid, rx_mac_last, rx_mac_err);
endinterface

// File: rtl/pause_timer.sv
// Pause hold-off timer: quanta down-counter paced by a per-quantum sub-counter.
// A load always wins over the running countdown.
module pause_timer #(
  parameter int unsigned QUANTUM_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] quanta,
  output logic        active,
  output logic [15:0] remaining
);

  localparam int unsigned SUB_W = (QUANTUM_CYCLES > 1) ? $clog2(QUANTUM_CYCLES) : 1;
  localparam logic [SUB_W-1:0] SUB_RELOAD = SUB_W'(QUANTUM_CYCLES - 1);

  logic [15:0]      quanta_cnt;
  logic [SUB_W-1:0] sub_cnt;

  // Load on apply, otherwise count down one quantum every QUANTUM_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quanta_cnt <= '0;
      sub_cnt    <= '0;
    end else if (load) begin
      quanta_cnt <= quanta;
      sub_cnt    <= SUB_RELOAD;
    end else if (quanta_cnt != '0) begin
      if (sub_cnt == '0) begin
        quanta_cnt <= quanta_cnt - 16'd1;
        sub_cnt    <= SUB_RELOAD;
      end else begin
        sub_cnt <= sub_cnt - SUB_W'(1);
      end
    end
  end

  assign active    = (quanta_cnt != '0);
  assign remaining = quanta_cnt;

endmodule

// File: rtl/pause_rx.sv
// 802.3x PAUSE frame receiver: parses the MAC-control header from the receive
// byte stream and drives the transmit hold-off timer.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | between frames; next valid byte is byte 0
//   HDR     | inside bytes 1..17, every field seen so far matches
//   MATCHED | full PAUSE header matched; waiting for a clean last byte
//   DISCARD | not a PAUSE frame (or short); drop until last
module pause_rx
  import eth_pkg::*;
#(
  parameter int unsigned QUANTUM_CYCLES = 64,
  parameter logic [47:0] STATION_ADDR   = 48'h0
) (
  input  logic             clk,
  input  logic             rst,
  pause_rx_if.slave        mac_rx,
  output logic             pause_active,
  output logic [15:0]      pause_quanta,
  output logic             pause_det,
  output logic [7:0]       pause_frm_cnt
);

  rx_state_e   state, state_nxt;
  logic [4:0]  byte_idx;
  logic        mc_ok, st_ok;
  logic        mc_cur, st_cur, hdr_bad;
  logic        apply;
  logic [15:0] quanta_cap;
  logic        byte_in, byte_last;

  assign byte_in   = mac_rx.rx_mac_valid;
  assign byte_last = mac_rx.rx_mac_valid & mac_rx.rx_mac_last;

  // Per-byte field compare; both DA candidates are tracked independently.
  always_comb begin
    mc_cur  = 1'b0;
    st_cur  = 1'b0;
    hdr_bad = 1'b0;
    if (byte_idx <= 5'd5) begin
      mc_cur  = ((byte_idx == 5'd0) || mc_ok) &&
                (mac_rx.rx_mac_data == addr_byte(PAUSE_DA, byte_idx[2:0]));
      st_cur  = ((byte_idx == 5'd0) || st_ok) &&
                (mac_rx.rx_mac_data == addr_byte(STATION_ADDR, byte_idx[2:0]));
      hdr_bad = !mc_cur && !st_cur;
    end
    case (byte_idx)
      5'd12:   hdr_bad = (mac_rx.rx_mac_data != MAC_CTRL_TYPE[15:8]);
      5'd13:   hdr_bad = (mac_rx.rx_mac_data != MAC_CTRL_TYPE[7:0]);
      5'd14:   hdr_bad = (mac_rx.rx_mac_data != PAUSE_OPCODE[15:8]);
      5'd15:   hdr_bad = (mac_rx.rx_mac_data != PAUSE_OPCODE[7:0]);
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and apply decision; nothing moves while rx_mac_valid is low.
  always_comb begin
    state_nxt = state;
    apply     = 1'b0;
    if (byte_in) begin
      unique case (state)
        IDLE:    if (!byte_last) state_nxt = HDR;
        HDR: begin
          if (byte_last)                     state_nxt = IDLE;
          else if (hdr_bad)                  state_nxt = DISCARD;
          else if (byte_idx == HDR_LAST_IDX) state_nxt = MATCHED;
        end
        MATCHED: begin
          if (byte_last) begin
            state_nxt = IDLE;
            apply     = !mac_rx.rx_mac_err;
          end
        end
        DISCARD: if (byte_last) state_nxt = IDLE;
      endcase
    end
  end

  // Byte index: counts valid bytes, parks at 18, restarts after last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= '0;
    end else if (byte_in) begin
      if (mac_rx.rx_mac_last)     byte_idx <= '0;
      else if (byte_idx != IDX_SAT) byte_idx <= byte_idx + 5'd1;
    end
  end

  // DA match history and big-endian quanta capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc_ok      <= 1'b0;
      st_ok      <= 1'b0;
      quanta_cap <= '0;
    end else if (byte_in) begin
      if (byte_idx <= 5'd5) begin
        mc_ok <= mc_cur;
        st_ok <= st_cur;
      end
      if (byte_idx == 5'd16) quanta_cap[15:8] <= mac_rx.rx_mac_data;
      if (byte_idx == 5'd17) quanta_cap[7:0]  <= mac_rx.rx_mac_data;
    end
  end

  // Detect pulse and saturating frame counter, aligned with the timer load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pause_det     <= 1'b0;
      pause_frm_cnt <= '0;
    end else begin
      pause_det <= apply;
      if (apply && (pause_frm_cnt != 8'hFF)) pause_frm_cnt <= pause_frm_cnt + 8'd1;
    end
  end

  pause_timer #(
    .QUANTUM_CYCLES(QUANTUM_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (apply),
    .quanta    (quanta_cap),
    .active    (pause_active),
    .remaining (pause_quanta)
  );

endmodule

// File: tb/tb_pause_rx.sv
// Self-checking bench for pause_rx: directed scenarios plus randomized frames,
// checked every cycle against a frame-level reference model.
module tb_pause_rx;

  localparam int unsigned QC  = 64;
  localparam logic [47:0] MC  = 48'h0180_C200_0001;
  localparam logic [47:0] STA = 48'h0200_0000_0005;

  logic        clk = 1'b0;
  logic        rst;
  logic        pause_active;
  logic [15:0] pause_quanta;
  logic        pause_det;
  logic [7:0]  pause_frm_cnt;

  pause_rx_if mac_rx();

  pause_rx #(
    .QUANTUM_CYCLES(QC),
    .STATION_ADDR  (STA)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mac_rx       (mac_rx),
    .pause_active (pause_active),
    .pause_quanta (pause_quanta),
    .pause_det    (pause_det),
    .pause_frm_cnt(pause_frm_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: a frame is a list of bytes; at its last byte the whole
  // list is judged, and the pause end time follows from N*QC arithmetic.
  int         cyc = 0;
  int         load_edge = 0;
  int         pause_n = 0;
  int         exp_cnt = 0;
  bit         exp_det = 1'b0;
  logic [7:0] frame_q[$];
  logic [7:0] frm[$];
  int         act_cnt = 0;
  int         det_seen = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_rem();
    int r;
    r = pause_n - (cyc - load_edge) / int'(QC);
    return (r > 0) ? r : 0;
  endfunction

  function automatic bit frame_good(input logic bad);
    logic [47:0] da;
    if (frame_q.size() < 19 || bad) return 1'b0;
    da = {frame_q[0], frame_q[1], frame_q[2], frame_q[3], frame_q[4], frame_q[5]};
    if (da != MC && da != STA) return 1'b0;
    if ({frame_q[12], frame_q[13]} != 16'h8808) return 1'b0;
    if ({frame_q[14], frame_q[15]} != 16'h0001) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    frame_q.delete();
    pause_n = 0;
    exp_cnt = 0;
    exp_det = 1'b0;
  endtask

  task automatic model_edge();
    cyc++;
    exp_det = 1'b0;
    if (rst) begin
      model_reset();
    end else if (mac_rx.rx_mac_valid) begin
      frame_q.push_back(mac_rx.rx_mac_data);
      if (mac_rx.rx_mac_last) begin
        if (frame_good(mac_rx.rx_mac_err)) begin
          load_edge = cyc;
          pause_n   = int'({frame_q[16], frame_q[17]});
          exp_det   = 1'b1;
          if (exp_cnt < 255) exp_cnt++;
        end
        frame_q.delete();
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_eq("pause_active",  32'(pause_active), 32'(exp_rem() != 0));
    chk_eq("pause_quanta",  32'(pause_quanta), exp_rem());
    chk_eq("pause_det",     32'(pause_det), 32'(exp_det));
    chk_eq("pause_frm_cnt", 32'(pause_frm_cnt), exp_cnt);
    if (pause_active) act_cnt++;
    if (pause_det) det_seen++;
  endtask

  task automatic set_idle();
    mac_rx.rx_mac_valid = 1'b0;
    mac_rx.rx_mac_data  = 8'($urandom);
    mac_rx.rx_mac_last  = 1'($urandom);
    mac_rx.rx_mac_err   = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      set_idle();
      tick();
    end
  endtask

  task automatic build_frame(input logic [47:0] da, input logic [15:0] et, input logic [15:0] op,
                             input logic [15:0] q, input int len);
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(da[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
    frm.push_back(et[15:8]);
    frm.push_back(et[7:0]);
    frm.push_back(op[15:8]);
    frm.push_back(op[7:0]);
    frm.push_back(q[15:8]);
    frm.push_back(q[7:0]);
    while (frm.size() < len) frm.push_back(8'($urandom));
    while (frm.size() > len) void'(frm.pop_back());
  endtask

  // Sends the first n_send bytes of frm; err is only meaningful on the last byte.
  task automatic send_frame(input bit bad, input int gap_pct, input int n_send);
    for (int i = 0; i < n_send; i++) begin
      for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
        set_idle();
        tick();
      end
      mac_rx.rx_mac_valid = 1'b1;
      mac_rx.rx_mac_data  = frm[i];
      mac_rx.rx_mac_last  = (i == frm.size() - 1);
      mac_rx.rx_mac_err   = (i == frm.size() - 1) ? bad : 1'($urandom);
      tick();
    end
    set_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    set_idle();
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    idle(3);

    // Multicast PAUSE, 3 quanta
    build_frame(MC, 16'h8808, 16'h0001, 16'h0003, 60);
    act_cnt = 0; det_seen = 0;
    send_frame(1'b0, 0, frm.size());
    idle(200);
    chk_eq("s1_active_cycles", act_cnt, 192);
    chk_eq("s1_det_pulses", det_seen, 1);
    chk_eq("s1_frm_cnt", 32'(pause_frm_cnt), 1);

    // Same frame, bad FCS
    build_frame(MC, 16'h8808, 16'h0001, 16'h0003, 60);
    act_cnt = 0; det_seen = 0;
    send_frame(1'b1, 0, frm.size());
    idle(20);
    chk_eq("s2_active_cycles", act_cnt, 0);
    chk_eq("s2_det_pulses", det_seen, 0);

    // Wrong ethertype, then wrong opcode
    build_frame(MC, 16'h0800, 16'h0001, 16'h0003, 60);
    act_cnt = 0; det_seen = 0;
    send_frame(1'b0, 0, frm.size());
    idle(5);
    build_frame(MC, 16'h8808, 16'h0002, 16'h0003, 60);
    send_frame(1'b0, 0, frm.size());
    idle(20);
    chk_eq("s3_active_cycles", act_cnt, 0);
    chk_eq("s3_det_pulses", det_seen, 0);

    // Quanta 10 cancelled by quanta 0
    build_frame(MC, 16'h8808, 16'h0001, 16'd10, 60);
    send_frame(1'b0, 0, frm.size());
    idle(100);
    chk_eq("s4_active_before_cancel", 32'(pause_active), 1);
    build_frame(MC, 16'h8808, 16'h0001, 16'd0, 60);
    send_frame(1'b0, 0, frm.size());
    chk_eq("s4_active_after_cancel", 32'(pause_active), 0);
    chk_eq("s4_det_on_cancel", 32'(pause_det), 1);
    idle(10);

    // Station address, 1 quantum, gaps mid-header
    build_frame(STA, 16'h8808, 16'h0001, 16'd1, 40);
    act_cnt = 0; det_seen = 0;
    send_frame(1'b0, 40, frm.size());
    idle(80);
    chk_eq("s5_active_cycles", act_cnt, 64);
    chk_eq("s5_det_pulses", det_seen, 1);

    // Reset during a pause with 5 quanta left, mid-frame
    build_frame(MC, 16'h8808, 16'h0001, 16'd8, 60);
    send_frame(1'b0, 0, frm.size());
    build_frame(MC, 16'h8808, 16'h0001, 16'd2, 60);
    send_frame(1'b0, 0, 9);
    for (int i = 0; i < 1000 && exp_rem() != 5; i++) idle(1);
    chk_eq("s6_quanta_before_rst", 32'(pause_quanta), 5);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk_eq("s6_rst_active", 32'(pause_active), 0);
    chk_eq("s6_rst_quanta", 32'(pause_quanta), 0);
    chk_eq("s6_rst_det", 32'(pause_det), 0);
    chk_eq("s6_rst_cnt", 32'(pause_frm_cnt), 0);
    tick();
    rst = 1'b0;
    build_frame(MC, 16'h8808, 16'h0001, 16'd2, 60);
    det_seen = 0;
    send_frame(1'b0, 0, frm.size());
    chk_eq("s6_det_after_rst", det_seen, 1);
    chk_eq("s6_cnt_after_rst", 32'(pause_frm_cnt), 1);
    idle(140);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      logic [47:0] da;
      logic [15:0] et, op;
      int sel;
      sel = int'($urandom_range(9));
      da  = (sel < 4) ? MC : (sel < 8) ? STA : {16'h0180, 32'($urandom)};
      et  = ($urandom_range(9) < 8) ? 16'h8808 : 16'h0800;
      op  = ($urandom_range(9) < 8) ? 16'h0001 : 16'h0002;
      build_frame(da, et, op, 16'($urandom_range(3)), int'($urandom_range(12, 64)));
      send_frame($urandom_range(5) == 0, 20, frm.size());
      idle(int'($urandom_range(150)));
    end

    // Back-to-back minimum PAUSE frames to saturate the counter
    for (int f = 0; f < 260; f++) begin
      build_frame(MC, 16'h8808, 16'h0001, 16'd0, 19);
      send_frame(1'b0, 0, frm.size());
    end
    idle(3);
    chk_eq("sat_frm_cnt", 32'(pause_frm_cnt), 255);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
